// File: rtl/control_cmd_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_cmd_serializer_pkg                                    |
// | Brief    : Command codes, sizing helpers and the opcode -> payload       |
// |            length rule shared by the serializer and the control unit.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package control_cmd_serializer_pkg;

  // Longest command on the wire: opcode + 6 payload bytes.
  localparam int CMD_MAX_BYTES = 7;

  localparam logic [7:0] COMMAND_BEGIN_PROGRAM      = 8'h01;
  localparam logic [7:0] COMMAND_END_PROGRAM        = 8'h02;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_INSTR  = 8'h03;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_0  = 8'h04;
  localparam logic [7:0] COMMAND_WRITE_BLOCK_REG_1  = 8'h05;
  localparam logic [7:0] COMMAND_ALLOC_DELAY        = 8'h06;
  localparam logic [7:0] COMMAND_SET_INPUT_GAIN     = 8'h07;
  localparam logic [7:0] COMMAND_SET_OUTPUT_GAIN    = 8'h08;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_0 = 8'h09;
  localparam logic [7:0] COMMAND_UPDATE_BLOCK_REG_1 = 8'h0A;
  localparam logic [7:0] COMMAND_COMMIT_REG_UPDATES = 8'h0B;

  // Payload length (bytes after the opcode) and whether the opcode exists.
  typedef struct packed {
    logic       legal;
    logic [2:0] len;
  } cmd_len_t;

  function automatic int block_bytes_f(input int n_blocks);
    return (n_blocks > 256) ? 2 : 1;
  endfunction

  function automatic int data_bytes_f(input int data_width);
    return (data_width == 24) ? 3 : 2;
  endfunction

  function automatic cmd_len_t cmd_payload_len(input logic [7:0] opcode,
                                               input int block_bytes,
                                               input int data_bytes);
    cmd_len_t r;
    r.legal = 1'b1;
    r.len   = 3'd0;
    case (opcode)
      COMMAND_WRITE_BLOCK_INSTR:  r.len = 3'(block_bytes + 4);
      COMMAND_WRITE_BLOCK_REG_0,
      COMMAND_WRITE_BLOCK_REG_1,
      COMMAND_UPDATE_BLOCK_REG_0,
      COMMAND_UPDATE_BLOCK_REG_1: r.len = 3'(block_bytes + data_bytes);
      COMMAND_ALLOC_DELAY:        r.len = 3'd6;
      COMMAND_SET_INPUT_GAIN,
      COMMAND_SET_OUTPUT_GAIN:    r.len = 3'(data_bytes);
      COMMAND_BEGIN_PROGRAM,
      COMMAND_END_PROGRAM,
      COMMAND_COMMIT_REG_UPDATES: r.len = 3'd0;
      default:                    r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_cmd_serializer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_cmd_serializer_if                                     |
// | Brief    : Command handshake plus byte/next link of the serializer.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface control_cmd_serializer_if
  import control_cmd_serializer_pkg::*;
#(
  parameter int N_BLOCKS = 256
) ();
  localparam int BLOCK_BYTES = block_bytes_f(N_BLOCKS);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [7:0]               cmd_opcode;
  logic [8*BLOCK_BYTES-1:0] cmd_block;
  logic [31:0]              cmd_word0;
  logic [23:0]              cmd_word1;
  logic [7:0]               out_byte;
  logic                     out_valid;
  logic                     next;
  logic                     busy;
  logic                     cmd_error;
  logic                     ack_timeout;

  // Command source / control-unit side.
  modport master (
    output cmd_valid, cmd_opcode, cmd_block, cmd_word0, cmd_word1, next,
    input  cmd_ready, out_byte, out_valid, busy, cmd_error, ack_timeout
  );

  // Serializer side.
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_block, cmd_word0, cmd_word1, next,
    output cmd_ready, out_byte, out_valid, busy, cmd_error, ack_timeout
  );
endinterface
`default_nettype wire

// File: rtl/control_cmd_serializer_cmd_length_lut.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_cmd_serializer_cmd_length_lut                         |
// | Brief    : Combinational opcode -> {legal, payload length} lookup.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module control_cmd_serializer_cmd_length_lut
  import control_cmd_serializer_pkg::*;
#(
  parameter int BLOCK_BYTES = 1,
  parameter int DATA_BYTES  = 2
) (
  input  wire logic [7:0] i_opcode,
  output cmd_len_t        o_len
);
  // Same rule the control unit uses, so both ends agree on framing.
  assign o_len = cmd_payload_len(i_opcode, BLOCK_BYTES, DATA_BYTES);
endmodule
`default_nettype wire

// File: rtl/control_cmd_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : control_cmd_serializer                                        |
// | Brief    : Turns one decoded command into opcode + payload bytes, one    |
// |            byte per control-unit `next`, with an acknowledge timeout.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module control_cmd_serializer
  import control_cmd_serializer_pkg::*;
#(
  parameter int N_BLOCKS           = 256,
  parameter int DATA_WIDTH         = 16,
  parameter int ACK_TIMEOUT_CYCLES = 65536
) (
  input wire logic               clk,
  input wire logic               reset,
  control_cmd_serializer_if.slave bus
);
  localparam int BLOCK_BYTES = block_bytes_f(N_BLOCKS);
  localparam int DATA_BYTES  = data_bytes_f(DATA_WIDTH);
  localparam int SR_W        = 8 * CMD_MAX_BYTES;
  localparam int TW          = $clog2(ACK_TIMEOUT_CYCLES);
  // Raw widths of each command class before left alignment.
  localparam int W_INSTR     = 8 + 8 * BLOCK_BYTES + 32;
  localparam int W_REG       = 8 + 8 * BLOCK_BYTES + 8 * DATA_BYTES;
  localparam int W_GAIN      = 8 + 8 * DATA_BYTES;

  localparam logic [0:0]    c_idle     = 1'b0;
  localparam logic [0:0]    c_send     = 1'b1;
  // The counter sits at this value on the last cycle before it would reach
  // ACK_TIMEOUT_CYCLES-1, so the abort registers as the counter gets there.
  localparam logic [TW-1:0] c_tmo_last = TW'(ACK_TIMEOUT_CYCLES - 2);

  logic [0:0]      state_q, state_d;
  logic [SR_W-1:0] sr_q, sr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      out_byte_q, out_byte_d;
  logic            out_valid_q, out_valid_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            tmo_pulse_q, tmo_pulse_d;

  cmd_len_t        w_len;
  logic            w_accept;
  logic [SR_W-1:0] w_load;

  control_cmd_serializer_cmd_length_lut #(
    .BLOCK_BYTES (BLOCK_BYTES),
    .DATA_BYTES  (DATA_BYTES)
  ) u_len_lut (
    .i_opcode (bus.cmd_opcode),
    .o_len    (w_len)
  );

  assign w_accept = (state_q == c_idle) && ready_q && bus.cmd_valid;

  // Left-align the command so the opcode sits in the top byte of the shifter.
  always_comb begin
    case (bus.cmd_opcode)
      COMMAND_WRITE_BLOCK_INSTR:
        w_load = SR_W'({bus.cmd_opcode, bus.cmd_block, bus.cmd_word0}) << (SR_W - W_INSTR);
      COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1,
      COMMAND_UPDATE_BLOCK_REG_0, COMMAND_UPDATE_BLOCK_REG_1:
        w_load = SR_W'({bus.cmd_opcode, bus.cmd_block, bus.cmd_word0[8*DATA_BYTES-1:0]})
                 << (SR_W - W_REG);
      COMMAND_ALLOC_DELAY:
        w_load = {bus.cmd_opcode, bus.cmd_word0[23:0], bus.cmd_word1};
      COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN:
        w_load = SR_W'({bus.cmd_opcode, bus.cmd_word0[8*DATA_BYTES-1:0]}) << (SR_W - W_GAIN);
      default:
        w_load = {bus.cmd_opcode, {(SR_W - 8){1'b0}}};
    endcase
  end

  // Accept/send/timeout sequencing; the outputs are registered from state.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    out_byte_d  = out_byte_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    tmo_pulse_d = 1'b0;
    if (state_q == c_idle) begin
      if (w_accept) begin
        tmo_d = '0;
        if (w_len.legal) begin
          state_d = c_send;
          sr_d    = w_load;
          cnt_d   = 3'd1 + w_len.len;
        end else begin
          err_d = 1'b1;
        end
      end
    end else begin
      out_valid_d = 1'b1;
      out_byte_d  = sr_q[SR_W-1 -: 8];
      if (bus.next) begin
        // Byte consumed; the new top byte shows one cycle later, which the
        // control unit's post-next wait cycle tolerates.
        sr_d  = sr_q << 8;
        cnt_d = cnt_q - 3'd1;
        tmo_d = '0;
        if (cnt_q == 3'd1) begin
          state_d     = c_idle;
          out_valid_d = 1'b0;
        end
      end else if (tmo_q == c_tmo_last) begin
        // Abandon the command; the control unit recovers on its own timeout.
        state_d     = c_idle;
        out_valid_d = 1'b0;
        sr_d        = '0;
        cnt_d       = 3'd0;
        tmo_d       = '0;
        tmo_pulse_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
    // A rejected opcode holds off the next accept for one cycle.
    ready_d = (state_d == c_idle) && !err_d;
    busy_d  = (state_d == c_send);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= c_idle;
      sr_q        <= '0;
      cnt_q       <= 3'd0;
      tmo_q       <= '0;
      out_byte_q  <= 8'd0;
      out_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign bus.cmd_ready   = ready_q;
  assign bus.out_byte    = out_byte_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = busy_q;
  assign bus.cmd_error   = err_q;
  assign bus.ack_timeout = tmo_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_control_cmd_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_control_cmd_serializer                                     |
// | Brief    : Self-checking bench: directed and random commands against a   |
// |            byte-list reference model, stalls, reject, timeout, reset.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_control_cmd_serializer;
  import control_cmd_serializer_pkg::*;

  // Bench configuration: 256 blocks -> 1 block byte, 16-bit data -> 2 bytes.
  localparam int TB_BB = 1;
  localparam int TB_DB = 2;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_t;
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] exp_q[$];
  bit         exp_legal;

  logic [7:0] legal_ops [11] = '{
    COMMAND_BEGIN_PROGRAM, COMMAND_END_PROGRAM, COMMAND_WRITE_BLOCK_INSTR,
    COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1, COMMAND_ALLOC_DELAY,
    COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN, COMMAND_UPDATE_BLOCK_REG_0,
    COMMAND_UPDATE_BLOCK_REG_1, COMMAND_COMMIT_REG_UPDATES};

  control_cmd_serializer_if #(.N_BLOCKS(256)) bus_a ();
  control_cmd_serializer_if #(.N_BLOCKS(256)) bus_t ();

  control_cmd_serializer #(
    .N_BLOCKS(256), .DATA_WIDTH(16), .ACK_TIMEOUT_CYCLES(65536)
  ) dut (
    .clk   (clk),
    .reset (rst_a),
    .bus   (bus_a.slave)
  );

  control_cmd_serializer #(
    .N_BLOCKS(256), .DATA_WIDTH(16), .ACK_TIMEOUT_CYCLES(16)
  ) dut_tmo (
    .clk   (clk),
    .reset (rst_t),
    .bus   (bus_t.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected wire bytes: opcode, block MSB first, then payload MSB first.
  function automatic void build_expected(input logic [7:0] op, input logic [7:0] blk,
                                         input logic [31:0] w0, input logic [23:0] w1);
    exp_q.delete();
    exp_legal = 1'b1;
    exp_q.push_back(op);
    case (op)
      COMMAND_WRITE_BLOCK_INSTR: begin
        for (int i = TB_BB - 1; i >= 0; i--) exp_q.push_back(8'((blk >> (8 * i)) & 8'hFF));
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'((w0 >> (8 * i)) & 32'hFF));
      end
      COMMAND_WRITE_BLOCK_REG_0, COMMAND_WRITE_BLOCK_REG_1,
      COMMAND_UPDATE_BLOCK_REG_0, COMMAND_UPDATE_BLOCK_REG_1: begin
        for (int i = TB_BB - 1; i >= 0; i--) exp_q.push_back(8'((blk >> (8 * i)) & 8'hFF));
        for (int i = TB_DB - 1; i >= 0; i--) exp_q.push_back(8'((w0 >> (8 * i)) & 32'hFF));
      end
      COMMAND_ALLOC_DELAY: begin
        for (int i = 2; i >= 0; i--) exp_q.push_back(8'((w0 >> (8 * i)) & 32'hFF));
        for (int i = 2; i >= 0; i--) exp_q.push_back(8'((w1 >> (8 * i)) & 24'hFF));
      end
      COMMAND_SET_INPUT_GAIN, COMMAND_SET_OUTPUT_GAIN: begin
        for (int i = TB_DB - 1; i >= 0; i--) exp_q.push_back(8'((w0 >> (8 * i)) & 32'hFF));
      end
      COMMAND_BEGIN_PROGRAM, COMMAND_END_PROGRAM, COMMAND_COMMIT_REG_UPDATES: ;
      default: begin
        exp_legal = 1'b0;
        exp_q.delete();
      end
    endcase
  endfunction

  // Offer one command, then play the control unit: read the byte, optionally
  // withhold next, pulse next, skip the one wait cycle, repeat.
  task automatic send_cmd(input logic [7:0] op, input logic [7:0] blk, input logic [31:0] w0,
                          input logic [23:0] w1, input int stall_idx, input int stall_len);
    int         t;
    int         hold;
    logic [7:0] b;
    build_expected(op, blk, w0, w1);
    t = 0;
    while (bus_a.cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_cmd", bus_a.cmd_ready, 1'b1);
    bus_a.cmd_opcode = op;
    bus_a.cmd_block  = blk;
    bus_a.cmd_word0  = w0;
    bus_a.cmd_word1  = w1;
    bus_a.cmd_valid  = 1'b1;
    @(negedge clk);
    // Scramble the inputs: the command must have been captured at accept.
    bus_a.cmd_valid  = 1'b0;
    bus_a.cmd_opcode = 8'($urandom());
    bus_a.cmd_block  = 8'($urandom());
    bus_a.cmd_word0  = $urandom();
    bus_a.cmd_word1  = 24'($urandom());
    if (!exp_legal) begin
      check("reject_err_pulse", bus_a.cmd_error, 1'b1);
      check("reject_no_valid", bus_a.out_valid, 1'b0);
      check("reject_not_busy", bus_a.busy, 1'b0);
      check("reject_ready_low", bus_a.cmd_ready, 1'b0);
      @(negedge clk);
      check("reject_err_once", bus_a.cmd_error, 1'b0);
      check("reject_ready_back", bus_a.cmd_ready, 1'b1);
      check("reject_still_no_valid", bus_a.out_valid, 1'b0);
      return;
    end
    check("accept_busy", bus_a.busy, 1'b1);
    check("accept_ready_low", bus_a.cmd_ready, 1'b0);
    check("accept_valid_latency", bus_a.out_valid, 1'b0);
    check("accept_no_err", bus_a.cmd_error, 1'b0);
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); i++) begin
      t = 0;
      while (bus_a.out_valid !== 1'b1 && t < 10) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("op%02h_byte%0d_valid", op, i), bus_a.out_valid, 1'b1);
      b = bus_a.out_byte;
      check($sformatf("op%02h_byte%0d", op, i), b, exp_q[i]);
      hold = (i == stall_idx) ? stall_len : int'($urandom_range(0, 2));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check($sformatf("op%02h_byte%0d_hold", op, i), {bus_a.out_valid, bus_a.out_byte},
              {1'b1, b});
      end
      bus_a.next = 1'b1;
      @(negedge clk);
      bus_a.next = 1'b0;
      if (i == exp_q.size() - 1) begin
        check("done_valid_low", bus_a.out_valid, 1'b0);
        check("done_not_busy", bus_a.busy, 1'b0);
        check("done_ready", bus_a.cmd_ready, 1'b1);
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [7:0] rop;
    rst_a = 1'b1;
    rst_t = 1'b1;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_opcode = 8'd0; bus_a.cmd_block = 8'd0;
    bus_a.cmd_word0 = 32'd0; bus_a.cmd_word1 = 24'd0; bus_a.next = 1'b0;
    bus_t.cmd_valid = 1'b0; bus_t.cmd_opcode = 8'd0; bus_t.cmd_block = 8'd0;
    bus_t.cmd_word0 = 32'd0; bus_t.cmd_word1 = 24'd0; bus_t.next = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_out_byte", bus_a.out_byte, 8'd0);
    check("rst_out_valid", bus_a.out_valid, 1'b0);
    check("rst_ready", bus_a.cmd_ready, 1'b0);
    check("rst_busy", bus_a.busy, 1'b0);
    check("rst_err", bus_a.cmd_error, 1'b0);
    check("rst_tmo", bus_a.ack_timeout, 1'b0);
    rst_a = 1'b0;
    rst_t = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_ready", bus_a.cmd_ready, 1'b1);
    check("post_rst_idle_valid", bus_a.out_valid, 1'b0);

    // next while idle does nothing.
    bus_a.next = 1'b1;
    @(negedge clk);
    bus_a.next = 1'b0;
    @(negedge clk);
    check("idle_next_valid", bus_a.out_valid, 1'b0);
    check("idle_next_busy", bus_a.busy, 1'b0);

    // Directed commands.
    send_cmd(COMMAND_WRITE_BLOCK_INSTR, 8'h12, 32'hDEADBEEF, 24'h0, -1, 0);
    send_cmd(COMMAND_ALLOC_DELAY, 8'h00, 32'h00ABCDEF, 24'h000102, -1, 0);
    send_cmd(COMMAND_END_PROGRAM, 8'h00, 32'h0, 24'h0, -1, 0);
    send_cmd(COMMAND_UPDATE_BLOCK_REG_1, 8'h05, 32'h00007FFF, 24'h0, -1, 0);
    send_cmd(COMMAND_WRITE_BLOCK_REG_0, 8'hA5, 32'h00001234, 24'h0, 2, 20);
    send_cmd(8'hFF, 8'h00, 32'h0, 24'h0, -1, 0);
    send_cmd(COMMAND_SET_OUTPUT_GAIN, 8'h00, 32'h0000C3E1, 24'h0, 0, 5);

    // Random commands, roughly one in eight unassigned.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) rop = 8'hC0 + 8'($urandom_range(0, 63));
      else rop = legal_ops[$urandom_range(0, 10)];
      send_cmd(rop, 8'($urandom()), $urandom(), 24'($urandom()),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
    end

    // Timeout on the 16-cycle instance: next is never given.
    @(negedge clk);
    check("tmo_ready", bus_t.cmd_ready, 1'b1);
    bus_t.cmd_opcode = COMMAND_WRITE_BLOCK_INSTR;
    bus_t.cmd_block  = 8'h33;
    bus_t.cmd_word0  = 32'h01020304;
    bus_t.cmd_valid  = 1'b1;
    @(negedge clk);
    bus_t.cmd_valid = 1'b0;
    check("tmo_busy", bus_t.busy, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("tmo_wait%0d", k), {bus_t.ack_timeout, bus_t.out_valid}, 2'b01);
    end
    @(negedge clk);
    check("tmo_pulse", bus_t.ack_timeout, 1'b1);
    check("tmo_valid_low", bus_t.out_valid, 1'b0);
    check("tmo_not_busy", bus_t.busy, 1'b0);
    @(negedge clk);
    check("tmo_pulse_once", bus_t.ack_timeout, 1'b0);
    check("tmo_ready_back", bus_t.cmd_ready, 1'b1);
    check("tmo_still_low", bus_t.out_valid, 1'b0);

    // Reset in the middle of SEND drops out_valid without a clock edge.
    bus_t.cmd_opcode = COMMAND_ALLOC_DELAY;
    bus_t.cmd_valid  = 1'b1;
    @(negedge clk);
    bus_t.cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_valid_before", bus_t.out_valid, 1'b1);
    #2;
    rst_t = 1'b1;
    #1;
    check("midrst_valid_async", bus_t.out_valid, 1'b0);
    check("midrst_busy_async", bus_t.busy, 1'b0);
    @(negedge clk);
    rst_t = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_ready_after", bus_t.cmd_ready, 1'b1);
    check("midrst_no_bytes", bus_t.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/control_cmd_serializer.md
Name: control_cmd_serializer

Overview:
Initiator side of the control byte protocol. It accepts one decoded command per handshake: opcode, block index and payload words. It serializes the command into the opcode byte plus payload bytes in the order the control unit's shift-in assembly expects, presenting each byte on out_byte/out_valid and advancing only on the control unit's registered `next` pulse. It sits between the host-facing command source (SPI/UART bridge or test sequencer) and control_unit's in_byte/in_valid/next port.

Parameters:
- n_blocks, 256: block address space. block_bytes = (n_blocks > 256) ? 2 : 1.
- data_width, 16: register data width. data_bytes = (data_width == 24) ? 3 : 2.
- ack_timeout_cycles, 65536: cycles to wait for `next` before aborting a command.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: serializer idle and accepting.
- cmd_opcode, in, 8: `COMMAND_*` code from controller.vh.
- cmd_block, in, 8*block_bytes: target block index.
- cmd_word0, in, 32: instr, register data (low data_bytes), gain (low data_bytes), or delay size (low 24).
- cmd_word1, in, 24: initial delay, used by ALLOC_DELAY only.
- out_byte, out, 8: byte to control_unit.in_byte.
- out_valid, out, 1: to control_unit.in_valid.
- next, in, 1: consume pulse from control_unit.
- busy, out, 1: a command is in flight.
- cmd_error, out, 1: one-cycle pulse; opcode rejected.
- ack_timeout, out, 1: one-cycle pulse; command aborted.

Behaviour:
- Reset values: out_byte=0, out_valid=0, cmd_ready=0 during reset and 1 in the first IDLE cycle after release, busy=0, cmd_error=0, ack_timeout=0. The shift register, counters and FSM are cleared; state is IDLE.
- Payload length by opcode:
  - WRITE_BLOCK_INSTR: block_bytes+4.
  - WRITE_BLOCK_REG_0/1 and UPDATE_BLOCK_REG_0/1: block_bytes+data_bytes.
  - ALLOC_DELAY: 6.
  - SET_INPUT_GAIN/SET_OUTPUT_GAIN: data_bytes.
  - BEGIN_PROGRAM, END_PROGRAM, COMMIT_REG_UPDATES: 0.
  - Any other opcode: rejected. cmd_error pulses in the cycle after accept and nothing is sent.
- Byte order after the opcode (transmission order):
  - Block index MSB first.
  - Then payload MSB first: instr [31:24]..[7:0]; data [data_bytes*8-1:0]; gain likewise; ALLOC_DELAY sends size[23:16], [15:8], [7:0], then init[23:16], [15:8], [7:0].
- Accept: cmd_valid && cmd_ready in IDLE.
  - Load a 7-byte left-aligned shift register and a remaining-count of 1+payload length.
  - Go to SEND; busy=1 and cmd_ready=0 from the next cycle.
- SEND:
  - out_valid=1 and out_byte = top byte, registered, so they appear the cycle after entering SEND.
  - Hold both stable until `next`=1 is sampled.
- On `next` sampled in SEND:
  - Shift left one byte and decrement the count.
  - If count was 1, go to IDLE: out_valid=0, busy=0 next cycle, cmd_ready=1.
  - Otherwise present the next byte on the following cycle. out_valid stays high; the control unit's one-cycle wait masks the stale byte.
- `next` sampled in IDLE is ignored.
- Back-to-back commands: a new command may be accepted in the first IDLE cycle. Minimum one IDLE cycle between commands.
- Control-unit EXECUTE, SWAP_WAIT and RESET_WAIT stalls appear as an absent `next`. The serializer simply holds the current byte.
- Timeout:
  - The counter resets on every `next` or accept and increments in SEND.
  - Reaching ack_timeout_cycles-1 causes: ack_timeout pulse, out_valid=0, shift register cleared, return to IDLE.
  - A partially sent command is abandoned; the control unit's own timeout recovers its state.
- Reset mid-command: out_valid drops immediately (asynchronous). No further bytes are sent.

Decomposition:
- Shared package/header (controller.vh):
  - `COMMAND_*` codes.
  - Localparam functions for block_bytes and data_bytes.
  - A `CMD_MAX_BYTES` = 7 constant.
  - An opcode→payload-length function, shared with control_unit so both ends agree.
- One natural sub-module, cmd_length_lut: combinational opcode → {length, legal}.
- FSM and shift register stay in the top module.

Test Plan:
- WRITE_BLOCK_INSTR, block 0x12, word0 0xDEADBEEF, `next` one cycle after each out_valid → bytes opcode, 0x12, 0xDE, 0xAD, 0xBE, 0xEF; a control_unit model drives instr_out=0xDEADBEEF, block_target=0x12.
- ALLOC_DELAY, word0 0x00ABCDEF, word1 0x000102 → 7 bytes opcode, AB, CD, EF, 00, 01, 02; delay_size_out=0xABCDEF, init_delay_out=0x000102.
- END_PROGRAM (no payload) then immediately UPDATE_BLOCK_REG_1, block 5, data 0x7FFF → END byte only, one IDLE cycle, then opcode, 0x05, 0x7F, 0xFF.
- Stall: withhold `next` for 20 cycles mid-command → out_byte/out_valid stable for 20 cycles; transmission resumes correctly afterward.
- Opcode 0xFF (unassigned) → cmd_error pulses once, out_valid never rises, cmd_ready returns next cycle.
- ack_timeout_cycles=16, never assert `next` → ack_timeout pulses at cycle 16 of SEND, out_valid=0, IDLE; asserting reset mid-SEND clears out_valid within the same cycle.
